// File: rtl/toggle_rom_responder.sv
// Toggle req/ack ROM responder: one read at a time to a variable-latency backing port.
// Define TOGGLE_ROM_CACHE_EN to add a one-entry last-address cache with a hit path.
module toggle_rom_responder #(
    parameter int unsigned AW = 16
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          req,
    output logic          ack,
    input  logic [AW-1:0] addr,
    output logic [15:0]   q,
    input  logic          inhibit,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_valid,
    input  logic [15:0]   mem_data
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
`ifdef TOGGLE_ROM_CACHE_EN
    localparam logic [1:0] StDone  = 2'd3;
`endif

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          req_q, req_d;
    logic          ack_q, ack_d;
    logic [15:0]   q_q, q_d;
    logic          accept;

`ifdef TOGGLE_ROM_CACHE_EN
    logic          cache_valid_q, cache_valid_d;
    logic [AW-1:0] cache_tag_q, cache_tag_d;
    logic [15:0]   cache_data_q, cache_data_d;
    logic          cache_hit;

    assign cache_hit = cache_valid_q && (cache_tag_q == addr);
`endif

    assign accept   = (state_q == StIdle) && (req != ack_q) && !inhibit;
    assign ack      = ack_q;
    assign q        = q_q;
    assign mem_rd   = (state_q == StIssue);
    // The latched request address doubles as the held backing-port address.
    assign mem_addr = addr_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        req_d   = req_q;
        ack_d   = ack_q;
        q_d     = q_q;
`ifdef TOGGLE_ROM_CACHE_EN
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d = addr;
                    req_d  = req;
`ifdef TOGGLE_ROM_CACHE_EN
                    state_d = cache_hit ? StDone : StIssue;
`else
                    state_d = StIssue;
`endif
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (mem_valid) begin
                    q_d     = mem_data;
                    ack_d   = req_q;
                    state_d = StIdle;
`ifdef TOGGLE_ROM_CACHE_EN
                    // Data fetched during a download may already be stale; do not keep it.
                    if (!inhibit) begin
                        cache_valid_d = 1'b1;
                        cache_tag_d   = addr_q;
                        cache_data_d  = mem_data;
                    end
`endif
                end
            end
`ifdef TOGGLE_ROM_CACHE_EN
            StDone: begin
                q_d     = cache_data_q;
                ack_d   = req_q;
                state_d = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
`ifdef TOGGLE_ROM_CACHE_EN
        if (inhibit) begin
            cache_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            req_q   <= 1'b0;
            ack_q   <= 1'b0;
            q_q     <= 16'h0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
        end
    end

`ifdef TOGGLE_ROM_CACHE_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= 16'h0000;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
        end
    end
`endif

endmodule
